// File: rtl/simon_key_if.sv
// rtl/simon_key_if.sv - key-load and round-key stream bundle for the SIMON key scheduler
interface simon_key_if #(
  parameter int N = 16,
  parameter int M = 4
);
  logic           start;
  logic           decrypt;
  logic [N*M-1:0] key;
  logic           busy;
  logic           key_valid;
  logic           key_ready;
  logic [N-1:0]   key_out;
  logic [6:0]     key_index;
  logic           key_last;

  modport master (
    output start, decrypt, key, key_ready,
    input  busy, key_valid, key_out, key_index, key_last
  );

  modport slave (
    input  start, decrypt, key, key_ready,
    output busy, key_valid, key_out, key_index, key_last
  );
endinterface

// File: rtl/simon_key_scheduler.sv
// rtl/simon_key_scheduler.sv - SIMON key expansion into a word array, streamed forward or reversed
module simon_key_scheduler #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32
) (
  input  logic       clk,
  input  logic       rst,
  simon_key_if.slave bus
);
  localparam int IW = $clog2(T);

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  localparam logic [61:0] ZSEQ =
    (N == 16) ? Z0 :
    (N == 24) ? ((M == 3) ? Z0 : Z1) :
    (N == 32) ? ((M == 3) ? Z2 : Z3) :
    (N == 48) ? ((M == 2) ? Z2 : Z3) :
                ((M == 2) ? Z2 : (M == 3) ? Z3 : Z4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_next;

  logic [T-1:0][N-1:0] w;
  logic [6:0]          cnt;
  logic [6:0]          ptr;
  logic [5:0]          zi;
  logic                dir;

  logic [IW-1:0] cw;
  logic [N-1:0]  wm1, wm3, wmm, tmp0, tmp1, new_word;
  logic          zbit, expand_done, last, xfer;

  assign cw  = cnt[IW-1:0];
  assign wm1 = w[cw - IW'(1)];
  assign wmm = w[cw - IW'(M)];

  generate
    if (M == 4) begin : g_m4
      assign wm3 = w[cw - IW'(3)];
    end else begin : g_m23
      assign wm3 = '0;
    end
  endgenerate

  // zi tracks (i - M) mod 62 so the z lookup never needs a divider
  assign zbit     = ZSEQ[6'd61 - zi];
  assign tmp0     = {wm1[2:0], wm1[N-1:3]} ^ wm3;
  assign tmp1     = tmp0 ^ {tmp0[0], tmp0[N-1:1]};
  assign new_word = ~wmm ^ tmp1 ^ {{(N-1){1'b0}}, zbit} ^ N'(3);

  assign expand_done = (cnt == 7'(T));
  assign last        = (state == STREAM) && (dir ? (ptr == 7'd0) : (ptr == 7'(T-1)));
  assign xfer        = (state == STREAM) && bus.key_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = EXPAND;
      EXPAND:  if (expand_done) state_next = STREAM;
      STREAM:  if (xfer && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ptr <= '0;
      zi  <= '0;
      dir <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt <= 7'(M);
            zi  <= '0;
            dir <= bus.decrypt;
          end
        end
        EXPAND: begin
          if (expand_done) begin
            ptr <= dir ? 7'(T-1) : 7'd0;
          end else begin
            cnt <= cnt + 7'd1;
            zi  <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last)     ptr <= 7'd0;
            else if (dir) ptr <= ptr - 7'd1;
            else          ptr <= ptr + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The word array is deliberately not reset; only a new start overwrites it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && bus.start)
        w[M-1:0] <= bus.key;
      else if (state == EXPAND && !expand_done)
        w[cw] <= new_word;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.key_valid = (state == STREAM);
  assign bus.key_last  = last;
  assign bus.key_out   = (state == STREAM) ? w[ptr[IW-1:0]] : '0;
  assign bus.key_index = (state == STREAM) ? ptr : 7'd0;
endmodule

// File: tb/tb_simon_key_scheduler.sv
// tb/tb_simon_key_scheduler.sv - scoreboard bench for the SIMON key scheduler across several variants
module tb_simon_key_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simon_key_if #(.N(16), .M(4)) if16 ();
  simon_key_if #(.N(64), .M(4)) if64 ();
  simon_key_if #(.N(24), .M(3)) if24 ();
  simon_key_if #(.N(48), .M(2)) if48 ();

  simon_key_scheduler #(.N(16), .M(4), .T(32)) u16 (.clk(clk), .rst(rst), .bus(if16));
  simon_key_scheduler #(.N(64), .M(4), .T(72)) u64 (.clk(clk), .rst(rst), .bus(if64));
  simon_key_scheduler #(.N(24), .M(3), .T(36)) u24 (.clk(clk), .rst(rst), .bus(if24));
  simon_key_scheduler #(.N(48), .M(2), .T(52)) u48 (.clk(clk), .rst(rst), .bus(if48));

  logic         aux_start;
  logic [255:0] aux_key;
  assign if64.start = aux_start;  assign if64.decrypt = 1'b0;
  assign if64.key = aux_key;      assign if64.key_ready = 1'b1;
  assign if24.start = aux_start;  assign if24.decrypt = 1'b0;
  assign if24.key = aux_key[71:0]; assign if24.key_ready = 1'b1;
  assign if48.start = aux_start;  assign if48.decrypt = 1'b0;
  assign if48.key = aux_key[95:0]; assign if48.key_ready = 1'b1;

  typedef struct {
    logic [6:0]  idx;
    logic [63:0] word;
    logic        last;
  } exp_t;

  typedef struct {
    string       name;
    int          idx;
    logic [15:0] exp;
  } vec_t;

  localparam logic [63:0] KEY16 = 64'h1918_1110_0908_0100;
  localparam logic [63:0] KEYB  = 64'hdead_beef_0123_4567;
  localparam logic [63:0] KEYC  = 64'h0f1e_2d3c_4b5a_6978;

  exp_t        q16[$], q64[$], q24[$], q48[$];
  exp_t        e16, e64, e24, e48;
  int          total = 0;
  int          bad = 0;
  logic [63:0] mw [72];
  logic [15:0] got16 [32];
  logic [15:0] fwd16 [32];
  int          xfers16, xf64, xf24, xf48;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_out;
  logic [6:0]  prev_idx;
  logic [6:0]  last_idx16;
  logic [15:0] last_word16;
  vec_t        vecs [4];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra_xfer(string name);
    total++;
    bad++;
    $display("FAIL %s: transfer with no expected word queued", name);
  endtask

  function automatic logic [61:0] zrow(int s);
    case (s)
      0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  function automatic int zsel(int n, int m);
    if (n == 16) return 0;
    if (n == 24) return (m == 3) ? 0 : 1;
    if (n == 32) return (m == 3) ? 2 : 3;
    if (n == 48) return (m == 2) ? 2 : 3;
    return (m == 2) ? 2 : (m == 3) ? 3 : 4;
  endfunction

  function automatic logic [63:0] nmask(int n);
    return (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ror(logic [63:0] x, int r, int n);
    return ((x >> r) | (x << (n - r))) & nmask(n);
  endfunction

  function automatic logic [15:0] rol16(logic [15:0] x, int r);
    return (x << r) | (x >> (16 - r));
  endfunction

  task automatic model(int n, int m, int t, logic [255:0] k);
    logic [63:0] mask, tmp, zb;
    logic [61:0] z;
    mask = nmask(n);
    z = zrow(zsel(n, m));
    for (int i = 0; i < m; i++) mw[i] = 64'(k >> (n * i)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = ror(mw[i-1], 3, n);
      if (m == 4) tmp = tmp ^ mw[i-3];
      tmp = tmp ^ ror(tmp, 1, n);
      zb = 64'((z >> (61 - ((i - m) % 62))) & 62'd1);
      mw[i] = (~mw[i-m] & mask) ^ tmp ^ zb ^ 64'd3;
    end
  endtask

  task automatic go16(logic [63:0] k, logic dec);
    if16.key = k;
    if16.decrypt = dec;
    if16.start = 1'b1;
    model(16, 4, 32, {192'd0, k});
    for (int j = 0; j < 32; j++) begin
      int ix;
      ix = dec ? 31 - j : j;
      q16.push_back('{7'(ix), mw[ix], (j == 31)});
    end
    @(posedge clk); #1;
    if16.start = 1'b0;
  endtask

  task automatic wait_idle16(int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
    end while (if16.busy && n < budget);
    chk("idle_timeout16", 64'(if16.busy), 64'd0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if16.key_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_out16", 64'(if16.key_out), 64'(prev_out));
        chk("stall_idx16", 64'(if16.key_index), 64'(prev_idx));
      end
      if (if16.key_valid && if16.key_ready) begin
        if (q16.size() == 0) extra_xfer("extra16");
        else begin
          e16 = q16.pop_front();
          chk("idx16", 64'(if16.key_index), 64'(e16.idx));
          chk("word16", 64'(if16.key_out), e16.word);
          chk("last16", 64'(if16.key_last), 64'(e16.last));
        end
        got16[if16.key_index[4:0]] = if16.key_out;
        if (if16.key_last) begin
          last_idx16 = if16.key_index;
          last_word16 = if16.key_out;
        end
        xfers16++;
      end
      prev_stall = if16.key_valid && !if16.key_ready;
      prev_out = if16.key_out;
      prev_idx = if16.key_index;
    end
  end

  always @(negedge clk) begin
    if (!rst && if64.key_valid) begin
      if (q64.size() == 0) extra_xfer("extra64");
      else begin
        e64 = q64.pop_front();
        chk("idx64", 64'(if64.key_index), 64'(e64.idx));
        chk("word64", if64.key_out, e64.word);
        chk("last64", 64'(if64.key_last), 64'(e64.last));
      end
      xf64++;
    end
    if (!rst && if24.key_valid) begin
      if (q24.size() == 0) extra_xfer("extra24");
      else begin
        e24 = q24.pop_front();
        chk("idx24", 64'(if24.key_index), 64'(e24.idx));
        chk("word24", 64'(if24.key_out), e24.word);
        chk("last24", 64'(if24.key_last), 64'(e24.last));
      end
      xf24++;
    end
    if (!rst && if48.key_valid) begin
      if (q48.size() == 0) extra_xfer("extra48");
      else begin
        e48 = q48.pop_front();
        chk("idx48", 64'(if48.key_index), 64'(e48.idx));
        chk("word48", 64'(if48.key_out), e48.word);
        chk("last48", 64'(if48.key_last), 64'(e48.last));
      end
      xf48++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, n, guard;
    logic [15:0] x, y, t;

    vecs[0] = '{"k0", 0, 16'h0100};
    vecs[1] = '{"k1", 1, 16'h0908};
    vecs[2] = '{"k2", 2, 16'h1110};
    vecs[3] = '{"k3", 3, 16'h1918};

    rst = 1'b1;
    if16.start = 1'b0; if16.decrypt = 1'b0; if16.key = '0; if16.key_ready = 1'b0;
    aux_start = 1'b0; aux_key = '0;
    xfers16 = 0; xf64 = 0; xf24 = 0; xf48 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(if16.busy), 64'd0);
    chk("rst_valid", 64'(if16.key_valid), 64'd0);
    chk("rst_last", 64'(if16.key_last), 64'd0);
    chk("rst_out", 64'(if16.key_out), 64'd0);
    chk("rst_index", 64'(if16.key_index), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // forward 16/4 with latency measurement
    if16.key_ready = 1'b1;
    go16(KEY16, 1'b0);
    @(negedge clk);
    chk("busy_after_start", 64'(if16.busy), 64'd1);
    chk("valid_during_expand", 64'(if16.key_valid), 64'd0);
    first = 0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); @(negedge clk);
      if (if16.key_valid) begin
        first = e;
        break;
      end
    end
    chk("first_valid_edge", 64'(first), 64'd29);
    wait_idle16(100, n);
    chk("busy_drop_cycles", 64'(n), 64'd32);
    chk("valid_after_last", 64'(if16.key_valid), 64'd0);
    chk("last_after_last", 64'(if16.key_last), 64'd0);
    chk("xfers_fwd", 64'(xfers16), 64'd32);
    chk("queue_fwd", 64'(q16.size()), 64'd0);
    foreach (vecs[i]) chk(vecs[i].name, 64'(got16[vecs[i].idx]), 64'(vecs[i].exp));
    x = 16'h6565; y = 16'h6877;
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ got16[r];
      y = t;
    end
    chk("simon32_64_cipher", 64'({x, y}), 64'h0000_0000_c69b_e9bb);
    for (int i = 0; i < 32; i++) fwd16[i] = got16[i];

    // reverse order
    xfers16 = 0;
    go16(KEY16, 1'b1);
    wait_idle16(200, n);
    chk("xfers_rev", 64'(xfers16), 64'd32);
    chk("queue_rev", 64'(q16.size()), 64'd0);
    chk("rev_last_idx", 64'(last_idx16), 64'd0);
    chk("rev_last_word", 64'(last_word16), 64'h0100);
    for (int i = 0; i < 32; i++) chk("rev_vs_fwd", 64'(got16[i]), 64'(fwd16[i]));

    // random backpressure
    xfers16 = 0;
    rand_ready = 1'b1;
    go16(KEY16, 1'b0);
    wait_idle16(2000, n);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    if16.key_ready = 1'b1;
    chk("xfers_bp", 64'(xfers16), 64'd32);
    chk("queue_bp", 64'(q16.size()), 64'd0);

    // start ignored during EXPAND, mid-STREAM and on the final transfer
    xfers16 = 0;
    go16(KEY16, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    if16.start = 1'b1; if16.key = KEYB; if16.decrypt = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    guard = 0;
    while (!if16.key_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ign_reach_stream", 64'(if16.key_valid), 64'd1);
    @(posedge clk); #1;
    if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    guard = 0;
    while (!(if16.key_valid && if16.key_last) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ign_reach_last", 64'(if16.key_last), 64'd1);
    if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    @(negedge clk);
    chk("ign_final_busy", 64'(if16.busy), 64'd0);
    chk("ign_final_valid", 64'(if16.key_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("ign_still_idle", 64'(if16.busy), 64'd0);
    chk("xfers_ign", 64'(xfers16), 64'd32);
    chk("queue_ign", 64'(q16.size()), 64'd0);

    // reset mid-stream at p = 10, then restart in reverse with a new key
    xfers16 = 0;
    go16(KEY16, 1'b0);
    guard = 0;
    while (!(if16.key_valid && if16.key_index == 7'd10) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rst_reach_p10", 64'(if16.key_index), 64'd10);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_busy", 64'(if16.busy), 64'd0);
    chk("midrst_valid", 64'(if16.key_valid), 64'd0);
    chk("midrst_index", 64'(if16.key_index), 64'd0);
    chk("midrst_xfers", 64'(xfers16), 64'd10);
    q16.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    xfers16 = 0;
    go16(KEYC, 1'b1);
    wait_idle16(200, n);
    chk("xfers_restart", 64'(xfers16), 64'd32);
    chk("queue_restart", 64'(q16.size()), 64'd0);

    // other variants, including the z-index wrap of 64/4
    aux_key = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
               64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
    model(64, 4, 72, aux_key);
    for (int j = 0; j < 72; j++) q64.push_back('{7'(j), mw[j], (j == 71)});
    model(24, 3, 36, {184'd0, aux_key[71:0]});
    for (int j = 0; j < 36; j++) q24.push_back('{7'(j), mw[j], (j == 35)});
    model(48, 2, 52, {160'd0, aux_key[95:0]});
    for (int j = 0; j < 52; j++) q48.push_back('{7'(j), mw[j], (j == 51)});
    aux_start = 1'b1;
    @(posedge clk); #1;
    aux_start = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); @(negedge clk);
      guard++;
    end while ((if64.busy || if24.busy || if48.busy) && guard < 400);
    chk("aux_idle", 64'({if64.busy, if24.busy, if48.busy}), 64'd0);
    chk("xfers64", 64'(xf64), 64'd72);
    chk("xfers24", 64'(xf24), 64'd36);
    chk("xfers48", 64'(xf48), 64'd52);
    chk("queue64", 64'(q64.size()), 64'd0);
    chk("queue24", 64'(q24.size()), 64'd0);
    chk("queue48", 64'(q48.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
